// File: rtl/square_writer.sv
// square_writer: fills a clipped square (or the whole grid) of a frame memory, one cell per clock.
// Ports: clock/reset_n (async active-low); cmd_valid/cmd_ready handshake with cmd_op (0 draw, 1 clear),
//   cmd_x, cmd_y, cmd_size, cmd_color; memory write side address_in {row, column}, data_in, wren;
//   status busy (filling) and done (one-cycle completion pulse).
module square_writer #(
   parameter int A = 9,
   parameter int S = 24,
   parameter int W = 5
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic           cmd_op,
   input  logic [W-1:0]   cmd_x,
   input  logic [A-W-1:0] cmd_y,
   input  logic [W-1:0]   cmd_size,
   input  logic [S-1:0]   cmd_color,
   output logic [A-1:0]   address_in,
   output logic [S-1:0]   data_in,
   output logic           wren,
   output logic           busy,
   output logic           done
);
   localparam int H = A - W;
   localparam int E = A + 1;
   localparam logic [E-1:0] ONE = E'(1);
   localparam logic [E-1:0] XMAX = E'((1 << W) - 1);
   localparam logic [E-1:0] YMAX = E'((1 << H) - 1);
   localparam logic [H-1:0] ROW_ONE = H'(1);
   localparam logic [A-1:0] ADDR_ONE = A'(1);
   typedef enum logic {IDLE, FILL} state_t;
   state_t state_q, state_d;
   logic [A-1:0] addr_q, addr_d;
   logic [S-1:0] data_q, data_d;
   logic wren_q, wren_d, done_q, done_d;
   logic [W-1:0] x0_q, x0_d, xe_q, xe_d, xe_c;
   logic [H-1:0] ye_q, ye_d, ye_c;
   logic [E-1:0] x_sum, y_sum;
   // The address register doubles as the {row, column} cursor; sums are one bit wider than the
   // address so clipping is a plain compare and never depends on wrap-around.
   always_comb begin
      x_sum = {{(E-W){1'b0}}, cmd_x} + {{(E-W){1'b0}}, cmd_size} - ONE;
      y_sum = {{(E-H){1'b0}}, cmd_y} + {{(E-W){1'b0}}, cmd_size} - ONE;
      xe_c = x_sum > XMAX ? '1 : x_sum[W-1:0];
      ye_c = y_sum > YMAX ? '1 : y_sum[H-1:0];
      state_d = state_q;
      addr_d = addr_q;
      data_d = data_q;
      wren_d = 1'b0;
      done_d = 1'b0;
      x0_d = x0_q;
      xe_d = xe_q;
      ye_d = ye_q;
      if (state_q == IDLE) begin
         if (cmd_valid) begin
            if (cmd_op || cmd_size != '0) begin
               state_d = FILL;
               wren_d = 1'b1;
               data_d = cmd_color;
               x0_d = cmd_op ? '0 : cmd_x;
               xe_d = cmd_op ? '1 : xe_c;
               ye_d = cmd_op ? '1 : ye_c;
               addr_d = cmd_op ? '0 : {cmd_y, cmd_x};
            end else begin
               done_d = 1'b1;
            end
         end
      end else if (addr_q == {ye_q, xe_q}) begin
         state_d = IDLE;
         done_d = 1'b1;
      end else begin
         wren_d = 1'b1;
         addr_d = addr_q[W-1:0] == xe_q ? {addr_q[A-1:W] + ROW_ONE, x0_q} : addr_q + ADDR_ONE;
      end
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q <= '0;
         data_q <= '0;
         wren_q <= 1'b0;
         done_q <= 1'b0;
         x0_q <= '0;
         xe_q <= '0;
         ye_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         data_q <= data_d;
         wren_q <= wren_d;
         done_q <= done_d;
         x0_q <= x0_d;
         xe_q <= xe_d;
         ye_q <= ye_d;
      end
   end
   assign cmd_ready = state_q == IDLE;
   assign busy = state_q == FILL;
   assign address_in = addr_q;
   assign data_in = data_q;
   assign wren = wren_q;
   assign done = done_q;
endmodule

// File: tb/tb_square_writer.sv
// tb_square_writer: scoreboard bench for square_writer (write order, clipping, timing, reset abort).
module tb_square_writer;
   logic clock = 1'b0;
   logic reset_n, cmd_valid, cmd_ready, cmd_op, wren, busy, done;
   logic [4:0] cmd_x, cmd_size;
   logic [3:0] cmd_y;
   logic [23:0] cmd_color, data_in;
   logic [8:0] address_in;
   int n_vec = 0;
   int n_bad = 0;
   logic [32:0] exp_q[$];
   logic [32:0] mon_e;
   logic [23:0] mem[512];

   square_writer dut (
      .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_size(cmd_size), .cmd_color(cmd_color),
      .address_in(address_in), .data_in(data_in), .wren(wren), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (wren === 1'b1) begin
         mem[address_in] = data_in;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL write_unexpected: got addr %0d data %h, required no write", address_in, data_in);
         end else begin
            mon_e = exp_q.pop_front();
            if ({address_in, data_in} !== mon_e) begin
               n_bad++;
               $display("FAIL write_cell: got addr %0d data %h, required addr %0d data %h",
                        address_in, data_in, mon_e[32:24], mon_e[23:0]);
            end
         end
      end
   end

   task automatic push_expected(input logic op, input logic [4:0] x, input logic [3:0] y,
                                input logic [4:0] size, input logic [23:0] col, output int n);
      int xe, ye;
      n = 0;
      if (op) begin
         for (int i = 0; i < 512; i++) begin
            exp_q.push_back({9'(i), col});
            n++;
         end
      end else if (size != 0) begin
         xe = int'(x) + int'(size) - 1;
         ye = int'(y) + int'(size) - 1;
         if (xe > 31) xe = 31;
         if (ye > 15) ye = 15;
         for (int r = int'(y); r <= ye; r++)
            for (int c = int'(x); c <= xe; c++) begin
               exp_q.push_back({9'(r * 32 + c), col});
               n++;
            end
      end
   endtask

   task automatic issue(input logic op, input logic [4:0] x, input logic [3:0] y,
                        input logic [4:0] size, input logic [23:0] col, output int n);
      cmd_op = op;
      cmd_x = x;
      cmd_y = y;
      cmd_size = size;
      cmd_color = col;
      cmd_valid = 1'b1;
      push_expected(op, x, y, size, col, n);
      @(posedge clock);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic expect_timing(input int n, input string tag);
      for (int c = 1; c <= n + 1; c++) begin
         @(negedge clock);
         n_vec += 4;
         if (wren !== (c <= n)) begin
            n_bad++;
            $display("FAIL %s wren cycle T+%0d: got %b, required %b", tag, c, wren, c <= n);
         end
         if (busy !== (c <= n)) begin
            n_bad++;
            $display("FAIL %s busy cycle T+%0d: got %b, required %b", tag, c, busy, c <= n);
         end
         if (cmd_ready !== (c > n)) begin
            n_bad++;
            $display("FAIL %s cmd_ready cycle T+%0d: got %b, required %b", tag, c, cmd_ready, c > n);
         end
         if (done !== (c == n + 1)) begin
            n_bad++;
            $display("FAIL %s done cycle T+%0d: got %b, required %b", tag, c, done, c == n + 1);
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      n_vec += 6;
      if (wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL %s flags: got wren %b busy %b done %b, required 0 0 0", tag, wren, busy, done);
      end
      if (address_in !== 9'd0 || data_in !== 24'd0) begin
         n_bad++;
         $display("FAIL %s outputs: got addr %0d data %h, required 0 0", tag, address_in, data_in);
      end
      if (cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s cmd_ready: got %b, required 1", tag, cmd_ready);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      cmd_valid = 1'b0;
      cmd_op = 1'b0;
      cmd_x = '0;
      cmd_y = '0;
      cmd_size = '0;
      cmd_color = '0;
      #2 reset_n = 1'b0;
      #2 check_idle_outputs("reset_async");
      @(negedge clock);
      #2 reset_n = 1'b1;
      @(negedge clock);
      check_idle_outputs("reset_release");
   endtask

   task automatic test_draw();
      int n;
      issue(1'b0, 5'd2, 4'd3, 5'd2, 24'hFF0000, n);
      expect_timing(n, "draw_2_3_2");
      issue(1'b0, 5'd30, 4'd14, 5'd4, 24'h0000FF, n);
      expect_timing(n, "draw_clip_corner");
      issue(1'b0, 5'd10, 4'd10, 5'd7, 24'h0F0F0F, n);
      expect_timing(n, "draw_clip_rows");
      issue(1'b0, 5'd5, 4'd1, 5'd31, 24'h5A5A5A, n);
      expect_timing(n, "draw_max_size");
      issue(1'b0, 5'd0, 4'd0, 5'd1, 24'h010203, n);
      expect_timing(n, "draw_single");
   endtask

   task automatic test_size_zero();
      int n;
      n_vec++;
      if (cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL size_zero ready_before: got %b, required 1", cmd_ready);
      end
      issue(1'b0, 5'd7, 4'd2, 5'd0, 24'hABCDEF, n);
      expect_timing(n, "size_zero");
   endtask

   task automatic test_clear();
      int n;
      issue(1'b1, 5'd7, 4'd3, 5'd9, 24'h00FF00, n);
      expect_timing(n, "clear");
      for (int i = 0; i < 512; i++) begin
         n_vec++;
         if (mem[i] !== 24'h00FF00) begin
            n_bad++;
            $display("FAIL clear_readback addr %0d: got %h, required 00ff00", i, mem[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n1, n2;
      cmd_op = 1'b0;
      cmd_x = 5'd0;
      cmd_y = 4'd0;
      cmd_size = 5'd2;
      cmd_color = 24'h123456;
      cmd_valid = 1'b1;
      push_expected(1'b0, 5'd0, 4'd0, 5'd2, 24'h123456, n1);
      @(posedge clock);
      #1;
      cmd_x = 5'd31;
      cmd_y = 4'd15;
      cmd_size = 5'd3;
      cmd_color = 24'hABCDEF;
      push_expected(1'b0, 5'd31, 4'd15, 5'd3, 24'hABCDEF, n2);
      expect_timing(n1, "b2b_first");
      @(posedge clock);
      #1 cmd_valid = 1'b0;
      expect_timing(n2, "b2b_second");
   endtask

   task automatic test_reset_abort();
      int n;
      issue(1'b0, 5'd4, 4'd4, 5'd3, 24'hC0FFEE, n);
      repeat (3) @(negedge clock);
      #1 reset_n = 1'b0;
      #1 check_idle_outputs("abort_async");
      exp_q.delete();
      repeat (2) begin
         @(negedge clock);
         n_vec++;
         if (done !== 1'b0 || wren !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_hold: got done %b wren %b, required 0 0", done, wren);
         end
      end
      #2 reset_n = 1'b1;
      issue(1'b0, 5'd8, 4'd9, 5'd2, 24'h777777, n);
      expect_timing(n, "after_abort");
   endtask

   initial begin
      test_reset();
      test_draw();
      test_size_zero();
      test_clear();
      test_back_to_back();
      test_reset_abort();
      repeat (2) @(negedge clock);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
